// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-beat AXI3 slave backed by a 2^ADDR_W x 32-bit SRAM.
// Reads wait RD_DELAY cycles before the response. Writes accept AW and W in
// either order. Any burst request (len != 0) is refused with SLVERR.
module axi_sram_slave #(
   parameter int ADDR_W   = 16,
   parameter int RD_DELAY = 2
) (
   input  logic        aclk,
   input  logic        reset,
   // read address channel
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic [1:0]  arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   // read data channel
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   // write address channel
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic [1:0]  awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   // write data channel
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   // write response channel
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_t;
   typedef enum logic       {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;

   localparam int          DEPTH      = 1 << ADDR_W;
   localparam int          CNT_INIT_I = (RD_DELAY > 0) ? RD_DELAY - 1 : 0;
   localparam logic [3:0]  CNT_INIT   = CNT_INIT_I[3:0];
   localparam logic [1:0]  RESP_OKAY  = 2'b00;
   localparam logic [1:0]  RESP_SLV   = 2'b10;

   logic [31:0] mem [DEPTH];

   // Side-band fields and address bits outside the word index carry no meaning here.
   logic unused_ok;
   assign unused_ok = ^{arsize, arburst, arlock, arcache, arprot, araddr,
                        awsize, awburst, awlock, awcache, awprot, awaddr, wid, wlast};

   // ------------------------------------------------------------------ read path
   r_state_t          r_state, r_state_nxt;
   logic [3:0]        r_cnt;
   logic [3:0]        r_id_q;
   logic [ADDR_W-1:0] r_idx_q;
   logic              r_err_q;
   logic [31:0]       rdata_q;
   logic [3:0]        rid_q;
   logic [1:0]        rresp_q;
   logic              rlast_q;
   logic              ar_fire, r_enter;
   logic [ADDR_W-1:0] rd_idx;
   logic [3:0]        rd_id;
   logic              rd_err;

   assign ar_fire = arvalid && arready;
   assign r_enter = (r_state != R_RESP) && (r_state_nxt == R_RESP);
   // With RD_DELAY=0 the response is latched on the AR edge itself, so take the live request.
   assign rd_idx  = (r_state == R_IDLE) ? araddr[ADDR_W+1:2] : r_idx_q;
   assign rd_id   = (r_state == R_IDLE) ? arid : r_id_q;
   assign rd_err  = (r_state == R_IDLE) ? (arlen != 8'd0) : r_err_q;

   // Read state register.
   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge aclk) begin
      if (reset) r_state <= R_IDLE;
      else       r_state <= r_state_nxt;
   end

   // Read next-state: wait out RD_DELAY, then hold the beat until rready.
   always_comb begin
      r_state_nxt = r_state;
      unique case (r_state)
         R_IDLE:  if (ar_fire) r_state_nxt = (RD_DELAY == 0) ? R_RESP : R_WAIT;
         R_WAIT:  if (r_cnt == 4'd0) r_state_nxt = R_RESP;
         R_RESP:  if (rready) r_state_nxt = R_IDLE;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // Read datapath: capture the request, count down, latch the beat on R_RESP entry.
   // The mem read here sees pre-edge contents, so a same-edge write is not visible (read-first).
   always_ff @(posedge aclk) begin
      if (reset) begin
         r_cnt   <= 4'd0;
         r_id_q  <= 4'd0;
         r_idx_q <= '0;
         r_err_q <= 1'b0;
         rdata_q <= 32'd0;
         rid_q   <= 4'd0;
         rresp_q <= RESP_OKAY;
         rlast_q <= 1'b0;
      end else begin
         if (ar_fire) begin
            r_cnt   <= CNT_INIT;
            r_id_q  <= arid;
            r_idx_q <= araddr[ADDR_W+1:2];
            r_err_q <= (arlen != 8'd0);
         end else if (r_state == R_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (r_enter) begin
            rdata_q <= rd_err ? 32'd0 : mem[rd_idx];
            rid_q   <= rd_id;
            rresp_q <= rd_err ? RESP_SLV : RESP_OKAY;
            rlast_q <= 1'b1;
         end
      end
   end

   // Read outputs: forced to zero while reset is high.
   // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
   always_comb begin
      arready = 1'b0;
      rvalid  = 1'b0;
      rid     = 4'd0;
      rdata   = 32'd0;
      rresp   = RESP_OKAY;
      rlast   = 1'b0;
      if (!reset) begin
         arready = (r_state == R_IDLE);
         rvalid  = (r_state == R_RESP);
         rid     = rid_q;
         rdata   = rdata_q;
         rresp   = rresp_q;
         rlast   = rlast_q;
      end
   end

   // ----------------------------------------------------------------- write path
   w_state_t          w_state, w_state_nxt;
   logic              aw_held, w_held;
   logic [3:0]        aw_id_q;
   logic [ADDR_W-1:0] aw_idx_q;
   logic              aw_err_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;
   logic [3:0]        bid_q;
   logic [1:0]        bresp_q;
   logic              aw_fire, w_fire, w_both, w_enter, mem_we;
   logic [ADDR_W-1:0] wr_idx;
   logic [3:0]        wr_id;
   logic              wr_err;
   logic [31:0]       wr_data;
   logic [3:0]        wr_strb;

   assign aw_fire = awvalid && awready;
   assign w_fire  = wvalid && wready;
   assign w_both  = (aw_held || aw_fire) && (w_held || w_fire);
   assign w_enter = (w_state == W_IDLE) && w_both;
   assign mem_we  = w_enter && !wr_err && !reset;
   // Whichever half arrives on the completing edge comes straight from the bus.
   assign wr_idx  = aw_held ? aw_idx_q : awaddr[ADDR_W+1:2];
   assign wr_id   = aw_held ? aw_id_q  : awid;
   assign wr_err  = aw_held ? aw_err_q : (awlen != 8'd0);
   assign wr_data = w_held  ? wdata_q  : wdata;
   assign wr_strb = w_held  ? wstrb_q  : wstrb;

   // Write state register.
   always_ff @(posedge aclk) begin
      if (reset) w_state <= W_IDLE;
      else       w_state <= w_state_nxt;
   end

   // Write next-state: respond once both halves are in, release on bready.
   always_comb begin
      w_state_nxt = w_state;
      unique case (w_state)
         W_IDLE:  if (w_both) w_state_nxt = W_RESP;
         W_RESP:  if (bready) w_state_nxt = W_IDLE;
         default: w_state_nxt = W_IDLE;
      endcase
   end

   // Write datapath: hold each half until its partner arrives, then latch the response.
   always_ff @(posedge aclk) begin
      if (reset) begin
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         aw_id_q  <= 4'd0;
         aw_idx_q <= '0;
         aw_err_q <= 1'b0;
         wdata_q  <= 32'd0;
         wstrb_q  <= 4'd0;
         bid_q    <= 4'd0;
         bresp_q  <= RESP_OKAY;
      end else begin
         if (aw_fire) begin
            aw_held  <= 1'b1;
            aw_id_q  <= awid;
            aw_idx_q <= awaddr[ADDR_W+1:2];
            aw_err_q <= (awlen != 8'd0);
         end
         if (w_fire) begin
            w_held  <= 1'b1;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
         end
         if (w_enter) begin
            bid_q   <= wr_id;
            bresp_q <= wr_err ? RESP_SLV : RESP_OKAY;
         end
         if (w_state == W_RESP && bready) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
         end
      end
   end

   // Write outputs: forced to zero while reset is high.
   always_comb begin
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      bid     = 4'd0;
      bresp   = RESP_OKAY;
      if (!reset) begin
         awready = (w_state == W_IDLE) && !aw_held;
         wready  = (w_state == W_IDLE) && !w_held;
         bvalid  = (w_state == W_RESP);
         bid     = bid_q;
         bresp   = bresp_q;
      end
   end

   // Byte-lane memory write.
   // NOTE: the array has no reset; contents must survive reset and a reset would block RAM inference.
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: table of write/read-back vectors plus hand-written
// sequences for reset abandonment and same-edge read/write collision.
module tb_axi_sram_slave;

   localparam int RD_DELAY = 2;
   localparam int AR_SEL = 0, AW_SEL = 1, W_SEL = 2, AWW_SEL = 3;

   logic        aclk, reset;
   logic [3:0]  arid;    logic [31:0] araddr;  logic [7:0] arlen;
   logic [2:0]  arsize;  logic [1:0]  arburst; logic [1:0] arlock;
   logic [3:0]  arcache; logic [2:0]  arprot;  logic       arvalid, arready;
   logic [3:0]  rid;     logic [31:0] rdata;   logic [1:0] rresp;
   logic        rlast, rvalid, rready;
   logic [3:0]  awid;    logic [31:0] awaddr;  logic [7:0] awlen;
   logic [2:0]  awsize;  logic [1:0]  awburst; logic [1:0] awlock;
   logic [3:0]  awcache; logic [2:0]  awprot;  logic       awvalid, awready;
   logic [3:0]  wid;     logic [31:0] wdata;   logic [3:0] wstrb;
   logic        wlast, wvalid, wready;
   logic [3:0]  bid;     logic [1:0]  bresp;   logic       bvalid, bready;

   axi_sram_slave #(.ADDR_W(16), .RD_DELAY(RD_DELAY)) dut (
      .aclk(aclk), .reset(reset),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; } r_exp_t;
   typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;

   typedef struct {
      string       name;
      bit          do_wr;
      logic [3:0]  w_id;  logic [31:0] w_addr; logic [31:0] w_data;
      logic [3:0]  w_strb; logic [7:0] w_len;  int w_lead; logic [1:0] exp_bresp;
      logic [3:0]  r_id;  logic [31:0] r_addr; logic [7:0] r_len; int r_hold;
      logic [31:0] exp_rdata; logic [1:0] exp_rresp;
   } vec_t;

   r_exp_t rq[$];
   b_exp_t bq[$];
   int     n_pass  = 0;
   int     n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic check_r(input string name, output r_exp_t e);
      e = '0;
      if (rq.size() == 0) begin
         n_total++;
         $display("FAIL %s_rq: read beat with no queued expectation", name);
      end else begin
         e = rq.pop_front();
         check({name, "_rdata"}, 64'(rdata), 64'(e.data));
         check({name, "_rbeat"}, 64'({rvalid, rid, rresp, rlast}), 64'({1'b1, e.id, e.resp, 1'b1}));
      end
   endtask

   task automatic check_b(input string name);
      b_exp_t e;
      if (bq.size() == 0) begin
         n_total++;
         $display("FAIL %s_bq: write response with no queued expectation", name);
      end else begin
         e = bq.pop_front();
         check({name, "_b"}, 64'({bvalid, bid, bresp}), 64'({1'b1, e.id, e.resp}));
      end
   endtask

   // Called at posedge+1 with valid(s) driven; returns at posedge+1 after the handshake edge.
   task automatic handshake(input int sel, input string name);
      int   n;
      logic rdy;
      n   = 0;
      rdy = 1'b0;
      do begin
         @(negedge aclk);
         case (sel)
            AR_SEL:  rdy = arready;
            AW_SEL:  rdy = awready;
            W_SEL:   rdy = wready;
            default: rdy = awready && wready;
         endcase
         n++;
      end while (!rdy && n < 20);
      check({name, "_hs"}, 64'(rdy), 64'd1);
      @(posedge aclk); #1;
   endtask

   task automatic drive_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
      awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
   endtask

   task automatic drive_w(input logic [31:0] data, input logic [3:0] strb);
      wdata = data; wstrb = strb; wvalid = 1'b1;
   endtask

   // lead > 0: W goes lead cycles before AW; lead < 0: AW first; 0: together.
   task automatic do_write(input string name, input logic [3:0] id, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb, input logic [7:0] len,
                           input int lead, input bit leave_b);
      @(posedge aclk); #1;
      if (lead == 0) begin
         drive_aw(id, addr, len);
         drive_w(data, strb);
         handshake(AWW_SEL, name);
         awvalid = 1'b0; wvalid = 1'b0;
      end else if (lead > 0) begin
         drive_w(data, strb);
         handshake(W_SEL, name);
         wvalid = 1'b0;
         for (int i = 1; i < lead; i++) begin
            @(negedge aclk);
            check({name, "_gap"}, 64'({awready, wready, bvalid}), 64'(3'b100));
            @(posedge aclk); #1;
         end
         drive_aw(id, addr, len);
         handshake(AW_SEL, name);
         awvalid = 1'b0;
      end else begin
         drive_aw(id, addr, len);
         handshake(AW_SEL, name);
         awvalid = 1'b0;
         for (int i = 1; i < -lead; i++) begin
            @(negedge aclk);
            check({name, "_gap"}, 64'({awready, wready, bvalid}), 64'(3'b010));
            @(posedge aclk); #1;
         end
         drive_w(data, strb);
         handshake(W_SEL, name);
         wvalid = 1'b0;
      end
      @(negedge aclk);
      check_b(name);
      if (!leave_b) begin
         bready = 1'b1;
         @(posedge aclk); #1;
         bready = 1'b0;
         @(negedge aclk);
         check({name, "_bdone"}, 64'({bvalid, awready, wready}), 64'(3'b011));
      end
   endtask

   task automatic do_read(input string name, input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input int hold);
      r_exp_t e;
      int     lat;
      @(posedge aclk); #1;
      arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
      handshake(AR_SEL, name);
      arvalid = 1'b0;
      lat = 0;
      do begin
         @(negedge aclk);
         lat++;
      end while (!rvalid && lat < 40);
      check({name, "_lat"}, 64'(lat), 64'(RD_DELAY + 1));
      check_r(name, e);
      for (int i = 0; i < hold; i++) begin
         @(negedge aclk);
         check({name, "_hold"}, 64'({rvalid, arready, rid, rresp, rlast, rdata}),
               64'({1'b1, 1'b0, e.id, e.resp, 1'b1, e.data}));
      end
      rready = 1'b1;
      @(posedge aclk); #1;
      rready = 1'b0;
      @(negedge aclk);
      check({name, "_idle"}, 64'({rvalid, arready}), 64'(2'b01));
   endtask

   vec_t vecs[9];

   initial begin
      r_exp_t ce;

      vecs[0] = '{"same_cycle", 1'b1, 4'd3,  32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 8'd0,  0, 2'b00,
                  4'd5,  32'h0000_0100, 8'd0, 0, 32'hDEAD_BEEF, 2'b00};
      vecs[1] = '{"aw_first",   1'b1, 4'd1,  32'h0000_0200, 32'hFFFF_FFFF, 4'hF, 8'd0, -2, 2'b00,
                  4'd2,  32'h0000_0200, 8'd0, 0, 32'hFFFF_FFFF, 2'b00};
      vecs[2] = '{"w_first",    1'b1, 4'd4,  32'h0000_0200, 32'h1122_3344, 4'h5, 8'd0,  4, 2'b00,
                  4'd6,  32'h0000_0200, 8'd0, 0, 32'hFF22_FF44, 2'b00};
      vecs[3] = '{"strb_zero",  1'b1, 4'd7,  32'h0000_0200, 32'h0000_0000, 4'h0, 8'd0,  0, 2'b00,
                  4'd8,  32'h0000_0200, 8'd0, 0, 32'hFF22_FF44, 2'b00};
      vecs[4] = '{"awlen_err",  1'b1, 4'd9,  32'h0000_0100, 32'h1234_5678, 4'hF, 8'd1,  0, 2'b10,
                  4'd10, 32'h0000_0100, 8'd0, 0, 32'hDEAD_BEEF, 2'b00};
      vecs[5] = '{"arlen_err",  1'b0, 4'd0,  32'h0000_0000, 32'h0000_0000, 4'h0, 8'd0,  0, 2'b00,
                  4'd11, 32'h0000_0100, 8'd3, 0, 32'h0000_0000, 2'b10};
      vecs[6] = '{"stall",      1'b1, 4'd12, 32'h0000_0104, 32'hCAFE_F00D, 4'hF, 8'd0,  1, 2'b00,
                  4'd13, 32'h0000_0104, 8'd0, 5, 32'hCAFE_F00D, 2'b00};
      vecs[7] = '{"alias",      1'b1, 4'd14, 32'h0004_010B, 32'h0BAD_C0DE, 4'hF, 8'd0,  0, 2'b00,
                  4'd15, 32'h0000_0108, 8'd0, 0, 32'h0BAD_C0DE, 2'b00};
      vecs[8] = '{"byte_hi",    1'b1, 4'd0,  32'h0000_0104, 32'hAABB_CCDD, 4'h8, 8'd0, -1, 2'b00,
                  4'd1,  32'hFFFC_0104, 8'd0, 2, 32'hAAFE_F00D, 2'b00};

      reset = 1'b1;
      arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
      arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
      awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
      wid = '0; wdata = '0; wstrb = '0; wlast = 1'b1; wvalid = 1'b0; bready = 1'b0;

      // Reset state and release.
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      check("rst_ctrl", 64'({arready, awready, wready, rvalid, bvalid}), 64'(5'b00000));
      check("rst_data", 64'({rdata, rid, bid, rresp, bresp, rlast}), 64'd0);
      @(posedge aclk); #1;
      reset = 1'b0;
      @(negedge aclk);
      check("rst_release", 64'({arready, awready, wready, rvalid, bvalid}), 64'(5'b11100));

      // Table: write (optional) then read back, expectations queued at drive time.
      foreach (vecs[k]) begin
         if (vecs[k].do_wr) begin
            bq.push_back('{vecs[k].w_id, vecs[k].exp_bresp});
            do_write({vecs[k].name, "_wr"}, vecs[k].w_id, vecs[k].w_addr, vecs[k].w_data,
                     vecs[k].w_strb, vecs[k].w_len, vecs[k].w_lead, 1'b0);
         end
         rq.push_back('{vecs[k].r_id, vecs[k].exp_rdata, vecs[k].exp_rresp});
         do_read({vecs[k].name, "_rd"}, vecs[k].r_id, vecs[k].r_addr, vecs[k].r_len, vecs[k].r_hold);
      end

      // Reset while a read waits and a write response is pending.
      bq.push_back('{4'd2, 2'b00});
      do_write("rstseq_wr", 4'd2, 32'h0000_0300, 32'h55AA_55AA, 4'hF, 8'd0, 0, 1'b1);
      @(posedge aclk); #1;
      arid = 4'd3; araddr = 32'h0000_0100; arlen = 8'd0; arvalid = 1'b1;
      handshake(AR_SEL, "rstseq_ar");
      arvalid = 1'b0;
      reset = 1'b1;
      @(negedge aclk);
      check("rstseq_during", 64'({arready, awready, wready, rvalid, bvalid}), 64'(5'b00000));
      @(posedge aclk); #1;
      reset = 1'b0;
      @(negedge aclk);
      check("rstseq_after", 64'({arready, awready, wready, rvalid, bvalid}), 64'(5'b11100));
      for (int i = 0; i < 6; i++) begin
         @(negedge aclk);
         check("rstseq_quiet", 64'({rvalid, bvalid}), 64'(2'b00));
      end
      rq.push_back('{4'd4, 32'h55AA_55AA, 2'b00});
      do_read("rstseq_keep300", 4'd4, 32'h0000_0300, 8'd0, 0);
      rq.push_back('{4'd5, 32'hDEAD_BEEF, 2'b00});
      do_read("rstseq_keep100", 4'd5, 32'h0000_0100, 8'd0, 0);

      // Read latched on the same edge that writes the same word returns old data.
      bq.push_back('{4'd1, 2'b00});
      do_write("coll_pre", 4'd1, 32'h0000_0040, 32'h0000_000A, 4'hF, 8'd0, 0, 1'b0);
      rq.push_back('{4'd2, 32'h0000_000A, 2'b00});
      bq.push_back('{4'd3, 2'b00});
      @(posedge aclk); #1;
      arid = 4'd2; araddr = 32'h0000_0040; arlen = 8'd0; arvalid = 1'b1;
      handshake(AR_SEL, "coll_ar");
      arvalid = 1'b0;
      @(posedge aclk); #1;
      drive_aw(4'd3, 32'h0000_0040, 8'd0);
      drive_w(32'h0000_000B, 4'hF);
      @(negedge aclk);
      check("coll_wready", 64'({awready, wready, rvalid}), 64'(3'b110));
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge aclk);
      check_r("coll", ce);
      check_b("coll");
      rready = 1'b1; bready = 1'b1;
      @(posedge aclk); #1;
      rready = 1'b0; bready = 1'b0;
      rq.push_back('{4'd4, 32'h0000_000B, 2'b00});
      do_read("coll_after", 4'd4, 32'h0000_0040, 8'd0, 0);

      check("sb_drained", 64'(rq.size() + bq.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter ADDR_W, default 16, word-index width; memory depth is 2^ADDR_W 32-bit words.
REQ-002 Parameter RD_DELAY, default 2, extra cycles from AR handshake to rvalid; legal range 0..15.
REQ-003 aclk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read address; arlock/arcache/arprot are present and ignored.
REQ-006 arvalid in 1, arready out 1  read address handshake.
REQ-007 rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1; rready in 1.
REQ-008 awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2; awlock/awcache/awprot are present and ignored; awvalid in 1, awready out 1.
REQ-009 wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1; wready out 1; wid and wlast are ignored.
REQ-010 bid/bresp/bvalid  out  4/2/1; bready in 1.

Function
REQ-011 Word index = addr[ADDR_W+1:2]; higher address bits and addr[1:0] are ignored.
REQ-012 Read FSM states: R_IDLE, R_WAIT, R_RESP; arready=1 only in R_IDLE.
REQ-013 R_IDLE, arvalid=1: capture arid/araddr/arlen, go to R_WAIT with counter=RD_DELAY-1, or directly to R_RESP if RD_DELAY=0.
REQ-014 R_WAIT: decrement counter each cycle; at counter=0 go to R_RESP.
REQ-015 R_RESP entry edge latches rdata=mem[index], rresp=2'b00, rid=captured arid, rlast=1; rvalid=1 throughout R_RESP.
REQ-016 While rvalid=1 and rready=0, rid/rdata/rresp/rlast stay stable; rvalid=1 and rready=1 returns to R_IDLE next cycle.
REQ-017 Captured arlen!=0: single beat only, rresp=2'b10 (SLVERR), rdata=0, rlast=1.
REQ-018 AR-to-rvalid latency = RD_DELAY+1 cycles; at most one read is outstanding.
REQ-019 Write FSM states: W_IDLE, W_RESP.
REQ-020 W_IDLE: awready=1 while AW is not yet captured; wready=1 while W is not yet captured; AW and W are accepted in either order or in the same cycle.
REQ-021 On the edge where both AW and W are held: go to W_RESP, write mem[index] byte lanes enabled by wstrb[i] (bits 8i+7:8i), set bvalid=1, bid=captured awid, bresp=2'b00.
REQ-022 Captured awlen!=0: no memory write; bresp=2'b10.
REQ-023 W_RESP: awready=wready=0; bvalid held until bready=1, then W_IDLE next cycle with both capture flags cleared.
REQ-024 Read and write paths are independent and run concurrently.
REQ-025 Collision: read latch (R_RESP entry) and memory write on the same edge, same index -> rdata returns the old data (read-first).
REQ-026 wstrb=4'b0000 completes the handshake and returns a response with memory unchanged.

Reset
REQ-027 Reset forces R_IDLE and W_IDLE, clears counter and capture flags, and drives arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rdata=0, rid=0, bid=0, rresp=0, bresp=0, rlast=0 during the reset cycle; ready signals assert in the first cycle after reset deasserts.
REQ-028 Reset mid-transaction abandons it; no response is issued afterwards; memory contents are not cleared.

Verification
REQ-029 AW(id=3, addr=0x100) and W(data=0xDEADBEEF, strb=F) in the same cycle -> bvalid next cycle, bid=3, bresp=0; then AR(id=5, addr=0x100), RD_DELAY=2 -> rvalid 3 cycles after the handshake, rdata=0xDEADBEEF, rid=5, rlast=1.
REQ-030 W accepted 4 cycles before AW, strb=4'b0101, data=0x11223344 over 0xFFFFFFFF -> read returns 0xFF22FF44.
REQ-031 rready held 0 for 5 cycles with rvalid=1 -> rvalid, rdata, rid stable; arready=0 throughout; R_IDLE the cycle after rready=1.
REQ-032 arlen=3 -> single beat, rresp=2'b10, rdata=0, rlast=1; awlen=1 -> bresp=2'b10, memory unchanged.
REQ-033 Read of 0x40 (old 0xA) latched on the same edge as a write of 0xB to 0x40 -> rdata=0xA; a subsequent read returns 0xB.
REQ-034 Reset asserted in R_WAIT and with bvalid=1 -> rvalid=0, bvalid=0 for the reset cycle and afterwards; arready=awready=wready=1 one cycle after release.
